// File: rtl/muldiv_unit.sv
// Iterative integer multiply/divide unit for the LEGv8 execute stage.
// One shared add/subtract datapath does a shift-add multiply (LSB-first) or a
// restoring divide (MSB-first). Each operation takes WIDTH iterations plus a
// one-cycle sign-fix stage. Signed modes work on magnitudes, and the sign is
// corrected in the fix stage.
module muldiv_unit #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] ModeMul   = 3'b000;
    localparam logic [2:0] ModeSmulh = 3'b001;
    localparam logic [2:0] ModeUmulh = 3'b010;
    localparam logic [2:0] ModeSdiv  = 3'b100;
    localparam logic [2:0] ModeUdiv  = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StFix  = 2'b10
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       mode_q;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [WIDTH-1:0] addend_q;
    // Multiply: high half of product. Divide: partial remainder.
    logic [WIDTH-1:0] hi_q;
    // Multiply: multiplier shifting out / product low half shifting in.
    // Divide: dividend shifting out / quotient bits shifting in.
    logic [WIDTH-1:0] lo_q;
    logic             neg_res_q;
    logic             neg_rem_q;
    logic             dz_q;

    // Operand decode at start: classify the mode and take magnitudes for signed modes.
    logic             in_is_div;
    logic             in_signed;
    logic             in_sa;
    logic             in_sb;
    logic [WIDTH-1:0] in_mag_a;
    logic [WIDTH-1:0] in_mag_b;

    always_comb begin
        in_is_div = (mode == ModeSdiv) || (mode == ModeUdiv);
        in_signed = (mode == ModeSmulh) || (mode == ModeSdiv);
        in_sa     = in_signed & op_a[WIDTH-1];
        in_sb     = in_signed & op_b[WIDTH-1];
        in_mag_a  = in_sa ? -op_a : op_a;
        in_mag_b  = in_sb ? -op_b : op_b;
    end

    // One iteration of the shared datapath: add for multiply, trial-subtract for divide.
    logic             is_div;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   add_x;
    logic [WIDTH:0]   add_y;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    always_comb begin
        is_div = (mode_q == ModeSdiv) || (mode_q == ModeUdiv);
        trial  = {hi_q, lo_q[WIDTH-1]};
        if (is_div) begin
            add_x = trial;
            add_y = ~{1'b0, addend_q};
        end else begin
            add_x = {1'b0, hi_q};
            add_y = lo_q[0] ? {1'b0, addend_q} : '0;
        end
        sum = add_x + add_y + {{WIDTH{1'b0}}, is_div};
        if (is_div) begin
            // sum[WIDTH] set means the trial subtraction went negative, so restore.
            hi_d = sum[WIDTH] ? trial[WIDTH-1:0] : sum[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], ~sum[WIDTH]};
        end else begin
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Sign correction and output selection, registered in the fix stage.
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_result;
    logic [WIDTH-1:0]   fix_remainder;
    logic               fix_dz;

    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = neg_res_q ? -prod : prod;
        // Divide by zero returns a zero quotient. The remainder naturally ends up
        // as the dividend, because nothing is ever subtracted from it.
        quo_fix  = dz_q ? '0 : (neg_res_q ? -lo_q : lo_q);
        rem_fix  = neg_rem_q ? -hi_q : hi_q;
        fix_result    = '0;
        fix_remainder = '0;
        fix_dz        = 1'b0;
        case (mode_q)
            ModeMul: begin
                fix_result = prod_fix[WIDTH-1:0];
            end
            ModeSmulh, ModeUmulh: begin
                fix_result = prod_fix[2*WIDTH-1:WIDTH];
            end
            ModeSdiv, ModeUdiv: begin
                fix_result    = quo_fix;
                fix_remainder = rem_fix;
                fix_dz        = dz_q;
            end
            default: begin
                fix_result    = '0;
                fix_remainder = '0;
                fix_dz        = 1'b0;
            end
        endcase
    end

    // Control FSM with the datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mode_q      <= '0;
            addend_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dz_q        <= 1'b0;
            stall       <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    // A simultaneous flush suppresses the start.
                    if (start && !flush) begin
                        state_q   <= StRun;
                        cnt_q     <= '0;
                        mode_q    <= mode;
                        addend_q  <= in_is_div ? in_mag_b : in_mag_a;
                        lo_q      <= in_is_div ? in_mag_a : in_mag_b;
                        hi_q      <= '0;
                        neg_res_q <= in_sa ^ in_sb;
                        neg_rem_q <= in_sa;
                        dz_q      <= in_is_div && (op_b == '0);
                        stall     <= 1'b1;
                    end
                end
                StRun: begin
                    if (flush) begin
                        state_q <= StIdle;
                        stall   <= 1'b0;
                    end else begin
                        hi_q  <= hi_d;
                        lo_q  <= lo_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q <= StFix;
                        end
                    end
                end
                StFix: begin
                    state_q <= StIdle;
                    stall   <= 1'b0;
                    if (!flush) begin
                        result      <= fix_result;
                        remainder   <= fix_remainder;
                        div_by_zero <= fix_dz;
                        done        <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    stall   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit. Three instances (WIDTH 64, 8, 16) are
// driven by per-scenario tasks. Expected results are queued at issue time and
// compared by a per-instance monitor whenever done pulses.
module tb_muldiv_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [63:0] res;
        logic [63:0] rem;
        logic        dz;
    } exp_t;

    exp_t q64[$];
    exp_t q8[$];
    exp_t q16[$];

    logic        rst64, start64, flush64, stall64, done64, dz64;
    logic [2:0]  mode64;
    logic [63:0] a64, b64, res64, rem64;

    logic        rst8, start8, flush8, stall8, done8, dz8;
    logic [2:0]  mode8;
    logic [7:0]  a8, b8, res8, rem8;

    logic        rst16, start16, flush16, stall16, done16, dz16;
    logic [2:0]  mode16;
    logic [15:0] a16, b16, res16, rem16;

    muldiv_unit #(.WIDTH(64)) u_dut64 (
        .clk(clk), .reset(rst64), .start(start64), .flush(flush64), .mode(mode64),
        .op_a(a64), .op_b(b64), .stall(stall64), .done(done64), .result(res64),
        .remainder(rem64), .div_by_zero(dz64)
    );

    muldiv_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(rst8), .start(start8), .flush(flush8), .mode(mode8),
        .op_a(a8), .op_b(b8), .stall(stall8), .done(done8), .result(res8),
        .remainder(rem8), .div_by_zero(dz8)
    );

    muldiv_unit #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset(rst16), .start(start16), .flush(flush16), .mode(mode16),
        .op_a(a16), .op_b(b16), .stall(stall16), .done(done16), .result(res16),
        .remainder(rem16), .div_by_zero(dz16)
    );

    // Scoreboard monitors: every done pops one expectation.
    exp_t e64, e8, e16;

    always @(negedge clk) begin
        if (done64 === 1'b1) begin
            checks++;
            if (q64.size() == 0) begin
                errors++;
                $display("FAIL mon64 unexpected done: result=%h, required no done", res64);
            end else begin
                e64 = q64.pop_front();
                if ({res64, rem64, dz64} !== {e64.res, e64.rem, e64.dz}) begin
                    errors++;
                    $display("FAIL mon64 result: got res=%h rem=%h dz=%b, required res=%h rem=%h dz=%b",
                             res64, rem64, dz64, e64.res, e64.rem, e64.dz);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL mon8 unexpected done: result=%h, required no done", res8);
            end else begin
                e8 = q8.pop_front();
                if ({56'b0, res8, 56'b0, rem8, dz8} !== {e8.res, e8.rem, e8.dz}) begin
                    errors++;
                    $display("FAIL mon8 result: got res=%h rem=%h dz=%b, required res=%h rem=%h dz=%b",
                             res8, rem8, dz8, e8.res[7:0], e8.rem[7:0], e8.dz);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done16 === 1'b1) begin
            checks++;
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL mon16 unexpected done: result=%h, required no done", res16);
            end else begin
                e16 = q16.pop_front();
                if ({48'b0, res16, 48'b0, rem16, dz16} !== {e16.res, e16.rem, e16.dz}) begin
                    errors++;
                    $display("FAIL mon16 result: got res=%h rem=%h dz=%b, required res=%h rem=%h dz=%b",
                             res16, rem16, dz16, e16.res[15:0], e16.rem[15:0], e16.dz);
                end
            end
        end
    end

    // Issue tasks: called at a negedge; they return one negedge later with start low.
    task automatic issue64(input logic [2:0] m, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] er, input logic [63:0] erem, input logic edz);
        exp_t e;
        e.res = er; e.rem = erem; e.dz = edz;
        q64.push_back(e);
        mode64 = m; a64 = a; b64 = b; start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
    endtask

    task automatic issue8(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] er, input logic [7:0] erem, input logic edz);
        exp_t e;
        e.res = {56'b0, er}; e.rem = {56'b0, erem}; e.dz = edz;
        q8.push_back(e);
        mode8 = m; a8 = a; b8 = b; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic issue16(input logic [2:0] m, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] er, input logic [15:0] erem, input logic edz);
        exp_t e;
        e.res = {48'b0, er}; e.rem = {48'b0, erem}; e.dz = edz;
        q16.push_back(e);
        mode16 = m; a16 = a; b16 = b; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
    endtask

    // Wait tasks: count negedges until done is seen, bounded.
    task automatic wait64(output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (done64 !== 1'b1 && cyc < 200);
    endtask

    task automatic wait8(output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (done8 !== 1'b1 && cyc < 200);
    endtask

    task automatic wait16(output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (done16 !== 1'b1 && cyc < 200);
    endtask

    task automatic test_reset();
        rst64 = 1'b0; rst8 = 1'b0; rst16 = 1'b0;
        start64 = 1'b0; flush64 = 1'b0; mode64 = '0; a64 = '0; b64 = '0;
        start8 = 1'b0; flush8 = 1'b0; mode8 = '0; a8 = '0; b8 = '0;
        start16 = 1'b0; flush16 = 1'b0; mode16 = '0; a16 = '0; b16 = '0;
        #1;
        checks++;
        if ({stall64, done64, res64, rem64, dz64} !== '0) begin
            errors++;
            $display("FAIL reset64: got stall=%b done=%b res=%h rem=%h dz=%b, required all 0",
                     stall64, done64, res64, rem64, dz64);
        end
        checks++;
        if ({stall8, done8, res8, rem8, dz8} !== '0) begin
            errors++;
            $display("FAIL reset8: got stall=%b done=%b res=%h rem=%h dz=%b, required all 0",
                     stall8, done8, res8, rem8, dz8);
        end
        checks++;
        if ({stall16, done16, res16, rem16, dz16} !== '0) begin
            errors++;
            $display("FAIL reset16: got stall=%b done=%b res=%h rem=%h dz=%b, required all 0",
                     stall16, done16, res16, rem16, dz16);
        end
        repeat (3) @(negedge clk);
        rst64 = 1'b1; rst8 = 1'b1; rst16 = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul_latency();
        int done_at = 0;
        int stall_cnt = 0;
        logic stall_at_done = 1'b1;
        exp_t e;
        e.res = 64'hFFFF_FFFF_FFFF_FFEB; e.rem = '0; e.dz = 1'b0;
        q64.push_back(e);
        mode64 = 3'b000; a64 = 64'd7; b64 = 64'hFFFF_FFFF_FFFF_FFFD; start64 = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            start64 = 1'b0;
            if (stall64 === 1'b1) stall_cnt++;
            if (done64 === 1'b1 && done_at == 0) begin
                done_at = k;
                stall_at_done = stall64;
            end
        end
        checks++;
        if (done_at != 66) begin
            errors++;
            $display("FAIL mul64 latency: done seen at negedge %0d, required 66", done_at);
        end
        checks++;
        if (stall_cnt != 65) begin
            errors++;
            $display("FAIL mul64 stall length: got %0d cycles, required 65", stall_cnt);
        end
        checks++;
        if (stall_at_done !== 1'b0) begin
            errors++;
            $display("FAIL mul64 stall in done cycle: got %b, required 0", stall_at_done);
        end
    endtask

    task automatic test_mulh();
        int cyc;
        issue64(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 64'd0, 1'b0);
        wait64(cyc);
        checks++;
        if (cyc != 65) begin
            errors++;
            $display("FAIL umulh latency: got %0d, required 65", cyc);
        end
        issue64(3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        wait64(cyc);
        checks++;
        if (cyc != 65) begin
            errors++;
            $display("FAIL smulh latency: got %0d, required 65", cyc);
        end
    endtask

    task automatic test_div64();
        int cyc;
        issue64(3'b100, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
                64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        wait64(cyc);
        checks++;
        if (cyc != 65) begin
            errors++;
            $display("FAIL sdiv latency: got %0d, required 65", cyc);
        end
        issue64(3'b101, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0);
        wait64(cyc);
        issue64(3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h8000_0000_0000_0000, 64'd0, 1'b0);
        wait64(cyc);
        checks++;
        if (cyc != 65) begin
            errors++;
            $display("FAIL sdiv overflow latency: got %0d, required 65", cyc);
        end
    endtask

    task automatic test_div_by_zero();
        int cyc;
        issue8(3'b101, 8'h5A, 8'h00, 8'h00, 8'h5A, 1'b1);
        wait8(cyc);
        checks++;
        if (cyc != 9) begin
            errors++;
            $display("FAIL divzero latency: got %0d, required 9", cyc);
        end
        issue8(3'b000, 8'd3, 8'd4, 8'd12, 8'd0, 1'b0);
        wait8(cyc);
    endtask

    task automatic test_start_ignored();
        int cyc;
        issue8(3'b000, 8'd5, 8'd6, 8'd30, 8'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait8(cyc);
        checks++;
        if (cyc != 6) begin
            errors++;
            $display("FAIL start ignored latency: got %0d, required 6", cyc);
        end
    endtask

    task automatic test_flush();
        int dones = 0;
        mode8 = 3'b000; a8 = 8'd5; b8 = 8'd6; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        flush8 = 1'b1;
        @(negedge clk);
        flush8 = 1'b0;
        checks++;
        if (stall8 !== 1'b0) begin
            errors++;
            $display("FAIL flush stall: got %b, required 0", stall8);
        end
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done8 === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL flush no done: got %0d dones, required 0", dones);
        end
        checks++;
        if ({res8, rem8, dz8} !== {8'd30, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL flush outputs held: got res=%h rem=%h dz=%b, required res=1e rem=00 dz=0",
                     res8, rem8, dz8);
        end
    endtask

    task automatic test_back_to_back();
        int cyc1;
        int cyc2;
        issue8(3'b000, 8'd5, 8'd6, 8'd30, 8'd0, 1'b0);
        wait8(cyc1);
        issue8(3'b000, 8'd11, 8'd13, 8'd143, 8'd0, 1'b0);
        wait8(cyc2);
        checks++;
        if (cyc1 != 9) begin
            errors++;
            $display("FAIL b2b first latency: got %0d, required 9", cyc1);
        end
        checks++;
        if (cyc2 + 1 != 10) begin
            errors++;
            $display("FAIL b2b done spacing: got %0d, required 10", cyc2 + 1);
        end
    endtask

    task automatic test_illegal_and_udiv16();
        int cyc;
        issue16(3'b011, 16'd5, 16'd3, 16'd0, 16'd0, 1'b0);
        wait16(cyc);
        checks++;
        if (cyc != 17) begin
            errors++;
            $display("FAIL illegal latency: got %0d, required 17", cyc);
        end
        issue16(3'b101, 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);
        wait16(cyc);
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        int dones = 0;
        mode16 = 3'b100; a16 = 16'd100; b16 = 16'd7; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst16 = 1'b0;
        #1;
        checks++;
        if ({stall16, done16, res16, rem16, dz16} !== '0) begin
            errors++;
            $display("FAIL async reset16: got stall=%b done=%b res=%h rem=%h dz=%b, required all 0",
                     stall16, done16, res16, rem16, dz16);
        end
        @(negedge clk);
        @(negedge clk);
        rst16 = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done16 === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset abandons op: got %0d dones, required 0", dones);
        end
        issue16(3'b100, 16'hFFF7, 16'd2, 16'hFFFC, 16'hFFFF, 1'b0);
        wait16(cyc);
        checks++;
        if (cyc != 17) begin
            errors++;
            $display("FAIL sdiv16 latency: got %0d, required 17", cyc);
        end
    endtask

    initial begin
        test_reset();
        test_mul_latency();
        test_mulh();
        test_div64();
        test_div_by_zero();
        test_start_ignored();
        test_flush();
        test_back_to_back();
        test_illegal_and_udiv16();
        test_reset_mid_run();
        repeat (3) @(negedge clk);
        checks++;
        if (q64.size() + q8.size() + q16.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drained: got %0d pending results, required 0",
                     q64.size() + q8.size() + q16.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
